// File: rtl/video_timing_detector.sv
// video_timing_detector
// Measures the raster of a pclk-synchronous sync/DE stream: horizontal total
// and active pixels, vertical total and active lines, and raises `locked`
// once LOCK_FRAMES consecutive frames measure identically.
// Optional feature macro: VTD_INTERLACE_EN (field-qualified frame boundaries
// and the `interlaced` flag). Without it `field` is ignored and every vsync
// rise closes a frame.
module video_timing_detector #(
    parameter int H_W         = 12,
    parameter int V_W         = 11,
    parameter int LOCK_FRAMES = 2
) (
    input  logic           pclk,
    input  logic           rst_n,
    input  logic           enable,
    input  logic           vsync,
    input  logic           hsync,
    input  logic           de,
    input  logic           field,
    output logic [H_W-1:0] h_total,
    output logic [H_W-1:0] h_active,
    output logic [V_W-1:0] v_total,
    output logic [V_W-1:0] v_active,
    output logic           interlaced,
    output logic           meas_valid,
    output logic           locked
);

    localparam logic [H_W-1:0] H_MAX  = {H_W{1'b1}};
    localparam logic [V_W-1:0] V_MAX  = {V_W{1'b1}};
    localparam logic [3:0]     LOCK_N = 4'(LOCK_FRAMES);

    // IDLE: waiting to discard the first (partial) frame
    // PRIMED: next boundary latches the first real measurement
    // RUN: boundaries latch and compare against the previous frame
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRIMED,
        ST_RUN
    } state_t;

    // ------------------------------------------------------------------
    // Input pipeline: input reg (*_d), history reg (*_q), edge reg
    // ------------------------------------------------------------------
    logic vsync_d, hsync_d, de_d;
    logic vsync_q, hsync_q, de_q;
    logic vs_rise_q, hs_rise_q, de_fall_q, de_lvl_q;

    // Register inputs, then register the detected edges so that every
    // counter decision sees edges and levels from the same sample
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_d   <= 1'b0;
            hsync_d   <= 1'b0;
            de_d      <= 1'b0;
            vsync_q   <= 1'b0;
            hsync_q   <= 1'b0;
            de_q      <= 1'b0;
            vs_rise_q <= 1'b0;
            hs_rise_q <= 1'b0;
            de_fall_q <= 1'b0;
            de_lvl_q  <= 1'b0;
        end else begin
            vsync_d   <= vsync;
            hsync_d   <= hsync;
            de_d      <= de;
            vsync_q   <= vsync_d;
            hsync_q   <= hsync_d;
            de_q      <= de_d;
            vs_rise_q <= vsync_d & ~vsync_q;
            hs_rise_q <= hsync_d & ~hsync_q;
            de_fall_q <= de_q & ~de_d;
            de_lvl_q  <= de_d;
        end
    end

    // Frame boundary qualification
    logic frame_bnd;
`ifdef VTD_INTERLACE_EN
    logic field_d, field_lvl_q;
    logic f1_vs;

    // Field id follows the same two-stage path as the syncs
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            field_d     <= 1'b0;
            field_lvl_q <= 1'b0;
        end else begin
            field_d     <= field;
            field_lvl_q <= field_d;
        end
    end

    assign frame_bnd = vs_rise_q & ~field_lvl_q;
    assign f1_vs     = vs_rise_q &  field_lvl_q;
`else
    logic unused_field;
    assign unused_field = field;
    assign frame_bnd    = vs_rise_q;
`endif

    // ------------------------------------------------------------------
    // Counters
    // ------------------------------------------------------------------
    logic [H_W-1:0] h_cnt_q, h_cnt_d;
    logic [H_W-1:0] ha_cnt_q, ha_cnt_d;
    logic [H_W-1:0] line_ht_q, ht_line_d;
    logic [H_W-1:0] line_ha_q, ha_line_d;
    logic           line_has_de_q, line_has_de_d;
    logic [V_W-1:0] v_cnt_q, v_cnt_d, v_line_d;
    logic [V_W-1:0] va_cnt_q, va_cnt_d, va_line_d;

    // Next-state for the line/frame counters. The *_line_d values are the
    // measurements "as of this cycle", i.e. with a coincident hsync/de edge
    // already folded in, so a frame latch includes the line closing now.
    always_comb begin
        // pixel counter: saturating, reload to 1 at line start
        h_cnt_d   = (h_cnt_q == H_MAX) ? h_cnt_q : h_cnt_q + H_W'(1);
        ht_line_d = line_ht_q;
        if (hs_rise_q) begin
            ht_line_d = h_cnt_q;
            h_cnt_d   = H_W'(1);
        end

        // active pixel counter: capture on de fall before the line clear
        ha_cnt_d  = ha_cnt_q;
        if (de_lvl_q && ha_cnt_q != H_MAX)
            ha_cnt_d = ha_cnt_q + H_W'(1);
        ha_line_d = de_fall_q ? ha_cnt_q : line_ha_q;
        if (hs_rise_q)
            ha_cnt_d = de_lvl_q ? H_W'(1) : '0;

        // per-line activity flag, sampled then restarted at line start
        line_has_de_d = line_has_de_q | de_lvl_q;
        if (hs_rise_q)
            line_has_de_d = de_lvl_q;

        // line counters: hsync update first, frame reload afterwards
        v_line_d  = v_cnt_q;
        va_line_d = va_cnt_q;
        if (hs_rise_q && v_cnt_q != V_MAX)
            v_line_d = v_cnt_q + V_W'(1);
        if (hs_rise_q && line_has_de_q && va_cnt_q != V_MAX)
            va_line_d = va_cnt_q + V_W'(1);
        v_cnt_d  = frame_bnd ? '0 : v_line_d;
        va_cnt_d = frame_bnd ? '0 : va_line_d;
    end

    // Counter registers; disabling measurement restarts everything
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q       <= '0;
            ha_cnt_q      <= '0;
            line_ht_q     <= '0;
            line_ha_q     <= '0;
            line_has_de_q <= 1'b0;
            v_cnt_q       <= '0;
            va_cnt_q      <= '0;
        end else if (!enable) begin
            h_cnt_q       <= '0;
            ha_cnt_q      <= '0;
            line_ht_q     <= '0;
            line_ha_q     <= '0;
            line_has_de_q <= 1'b0;
            v_cnt_q       <= '0;
            va_cnt_q      <= '0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            ha_cnt_q      <= ha_cnt_d;
            line_ht_q     <= ht_line_d;
            line_ha_q     <= ha_line_d;
            line_has_de_q <= line_has_de_d;
            v_cnt_q       <= v_cnt_d;
            va_cnt_q      <= va_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Measurement latch and lock tracking
    // ------------------------------------------------------------------
    state_t         state_q;
    logic [3:0]     match_cnt_q, match_d;
    logic           locked_q, meas_valid_q;
    logic [H_W-1:0] h_total_q, h_active_q;
    logic [V_W-1:0] v_total_q, v_active_q;
    logic           meas_same;
    logic           h_timeout;

    assign meas_same = ({ht_line_d, ha_line_d, v_line_d, va_line_d} ==
                        {h_total_q, h_active_q, v_total_q, v_active_q});
    // h_cnt about to reach all-ones: hsync has gone missing
    assign h_timeout = (h_cnt_d == H_MAX);

    // Consecutive-match count for the frame being latched
    always_comb begin
        match_d = '0;
        if (state_q == ST_RUN && meas_same)
            match_d = (match_cnt_q >= LOCK_N) ? LOCK_N : match_cnt_q + 4'd1;
    end

    // Frame FSM: discard first frame, latch later ones, track lock
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            match_cnt_q  <= '0;
            locked_q     <= 1'b0;
            meas_valid_q <= 1'b0;
            h_total_q    <= '0;
            h_active_q   <= '0;
            v_total_q    <= '0;
            v_active_q   <= '0;
        end else if (!enable) begin
            state_q      <= ST_IDLE;
            match_cnt_q  <= '0;
            locked_q     <= 1'b0;
            meas_valid_q <= 1'b0;
        end else begin
            meas_valid_q <= 1'b0;
            if (frame_bnd) begin
                case (state_q)
                    ST_IDLE: state_q <= ST_PRIMED;
                    default: begin
                        state_q      <= ST_RUN;
                        meas_valid_q <= 1'b1;
                        h_total_q    <= ht_line_d;
                        h_active_q   <= ha_line_d;
                        v_total_q    <= v_line_d;
                        v_active_q   <= va_line_d;
                        match_cnt_q  <= match_d;
                        locked_q     <= (match_d == LOCK_N);
                    end
                endcase
            end
            if (h_timeout) begin
                match_cnt_q <= '0;
                locked_q    <= 1'b0;
            end
        end
    end

`ifdef VTD_INTERLACE_EN
    logic seen_f1_q, interlaced_q;

    // Remember any second-field vsync in the frame; publish it at the latch
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            seen_f1_q    <= 1'b0;
            interlaced_q <= 1'b0;
        end else if (!enable) begin
            seen_f1_q <= 1'b0;
        end else if (frame_bnd) begin
            if (state_q != ST_IDLE)
                interlaced_q <= seen_f1_q;
            seen_f1_q <= 1'b0;
        end else if (f1_vs) begin
            seen_f1_q <= 1'b1;
        end
    end

    assign interlaced = interlaced_q;
`else
    assign interlaced = 1'b0;
`endif

    assign h_total    = h_total_q;
    assign h_active   = h_active_q;
    assign v_total    = v_total_q;
    assign v_active   = v_active_q;
    assign meas_valid = meas_valid_q;
    assign locked     = locked_q;

endmodule

// File: tb/tb_video_timing_detector.sv
// Directed bench for video_timing_detector: 40-cycle lines (hsync 4 cycles,
// de from cycle 4), vsync on the last two lines of each frame so the vsync
// rise coincides with an hsync rise.
module tb_video_timing_detector;
    localparam int H_W = 12;
    localparam int V_W = 11;

    logic           pclk = 1'b0;
    logic           rst_n = 1'b0;
    logic           enable = 1'b0;
    logic           vsync = 1'b0;
    logic           hsync = 1'b0;
    logic           de = 1'b0;
    logic           field = 1'b0;
    logic [H_W-1:0] h_total, h_active;
    logic [V_W-1:0] v_total, v_active;
    logic           interlaced, meas_valid, locked;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int vs_cyc = 0;
    int mv_count = 0;
    int mv_cyc = 0;
    int mv_ht = 0, mv_ha = 0, mv_vt = 0, mv_va = 0;
    logic mv_lk = 1'b0, mv_il = 1'b0;

    video_timing_detector #(.H_W(H_W), .V_W(V_W), .LOCK_FRAMES(2)) dut (
        .pclk(pclk), .rst_n(rst_n), .enable(enable), .vsync(vsync),
        .hsync(hsync), .de(de), .field(field), .h_total(h_total),
        .h_active(h_active), .v_total(v_total), .v_active(v_active),
        .interlaced(interlaced), .meas_valid(meas_valid), .locked(locked)
    );

    always #5 pclk = ~pclk;

    always @(posedge pclk) cyc <= cyc + 1;

    // Record every meas_valid cycle and what was presented with it
    always @(negedge pclk) begin
        if (meas_valid === 1'b1) begin
            mv_count <= mv_count + 1;
            mv_cyc   <= cyc;
            mv_ht    <= int'(h_total);
            mv_ha    <= int'(h_active);
            mv_vt    <= int'(v_total);
            mv_va    <= int'(v_active);
            mv_lk    <= locked;
            mv_il    <= interlaced;
        end
    end

    task automatic drive_line(input int hact, input bit vs, input bit fld,
                              input int cfirst, input int clast);
        for (int c = cfirst; c <= clast; c++) begin
            if (vs && !vsync) vs_cyc = cyc;
            hsync = (c < 4);
            de    = (c >= 4) && (c < 4 + hact);
            vsync = vs;
            field = fld;
            @(posedge pclk); #1;
        end
    endtask

    task automatic run_lines(input int first, input int last, input int n,
                             input int hact, input bit fld);
        for (int l = first; l <= last; l++)
            drive_line((l < n - 2) ? hact : 0, (l >= n - 2), fld, 0, 39);
    endtask

    task automatic run_frame(input int n, input int hact, input bit fld);
        run_lines(0, n - 1, n, hact, fld);
    endtask

    task automatic idle(input int n);
        hsync = 1'b0; de = 1'b0; vsync = 1'b0; field = 1'b0;
        repeat (n) begin @(posedge pclk); #1; end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) begin @(posedge pclk); #1; end
        checks++;
        if ({h_total, h_active, v_total, v_active, interlaced, meas_valid, locked} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got ht=%0d ha=%0d vt=%0d va=%0d il=%b mv=%b lk=%b, expected all 0",
                     h_total, h_active, v_total, v_active, interlaced, meas_valid, locked);
        end
        rst_n = 1'b1;
        @(posedge pclk); #1;
    endtask

    task automatic test_progressive();
        int base;
        enable = 1'b1;
        base = mv_count;
        run_frame(10, 32, 0);
        checks++;
        if (mv_count !== base) begin
            errors++;
            $display("FAIL prog_discard: got %0d pulses, expected %0d", mv_count, base);
        end
        run_frame(10, 32, 0);
        checks++;
        if (mv_count !== base + 1) begin
            errors++;
            $display("FAIL prog_first_mv: got %0d pulses, expected %0d", mv_count, base + 1);
        end
        checks++;
        if (mv_ht != 40 || mv_ha != 32 || mv_vt != 10 || mv_va != 8) begin
            errors++;
            $display("FAIL prog_meas: got %0d/%0d/%0d/%0d, expected 40/32/10/8", mv_ht, mv_ha, mv_vt, mv_va);
        end
        checks++;
        if (mv_cyc - vs_cyc != 3) begin
            errors++;
            $display("FAIL prog_latency: got %0d edges, expected 3", mv_cyc - vs_cyc);
        end
        checks++;
        if (mv_lk !== 1'b0) begin
            errors++;
            $display("FAIL prog_lock1: got %b, expected 0", mv_lk);
        end
        run_frame(10, 32, 0);
        checks++;
        if (mv_lk !== 1'b0 || mv_count !== base + 2) begin
            errors++;
            $display("FAIL prog_lock2: got lk=%b pulses=%0d, expected lk=0 pulses=%0d", mv_lk, mv_count, base + 2);
        end
        run_frame(10, 32, 0);
        checks++;
        if (mv_lk !== 1'b1 || mv_count !== base + 3) begin
            errors++;
            $display("FAIL prog_lock3: got lk=%b pulses=%0d, expected lk=1 pulses=%0d", mv_lk, mv_count, base + 3);
        end
    endtask

    task automatic test_hact_change();
        logic exp_lk [3] = '{1'b0, 1'b0, 1'b1};
        run_frame(10, 31, 0);
        checks++;
        if (mv_ha != 31 || mv_lk !== 1'b0) begin
            errors++;
            $display("FAIL hact_glitch: got ha=%0d lk=%b, expected ha=31 lk=0", mv_ha, mv_lk);
        end
        for (int k = 0; k < 3; k++) begin
            run_frame(10, 32, 0);
            checks++;
            if (mv_ha != 32 || mv_lk !== exp_lk[k]) begin
                errors++;
                $display("FAIL hact_relock%0d: got ha=%0d lk=%b, expected ha=32 lk=%b", k, mv_ha, mv_lk, exp_lk[k]);
            end
        end
    endtask

    task automatic test_timeout();
        int base;
        logic exp_lk [3] = '{1'b0, 1'b0, 1'b1};
        base = mv_count;
        run_lines(0, 7, 10, 32, 0);
        idle(4000);
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL timeout_before_sat: got lk=%b, expected 1", locked);
        end
        idle(200);
        checks++;
        if (locked !== 1'b0 || mv_count !== base) begin
            errors++;
            $display("FAIL timeout_sat: got lk=%b pulses=%0d, expected lk=0 pulses=%0d", locked, mv_count, base);
        end
        run_lines(8, 9, 10, 32, 0);
        checks++;
        if (mv_count !== base + 1 || mv_ht != 4095 || mv_ha != 32 || mv_vt != 10 || mv_va != 8 || mv_lk !== 1'b0) begin
            errors++;
            $display("FAIL timeout_meas: got pulses=%0d %0d/%0d/%0d/%0d lk=%b, expected pulses=%0d 4095/32/10/8 lk=0",
                     mv_count, mv_ht, mv_ha, mv_vt, mv_va, mv_lk, base + 1);
        end
        for (int k = 0; k < 3; k++) begin
            run_frame(10, 32, 0);
            checks++;
            if (mv_ht != 40 || mv_lk !== exp_lk[k]) begin
                errors++;
                $display("FAIL timeout_relock%0d: got ht=%0d lk=%b, expected ht=40 lk=%b", k, mv_ht, mv_lk, exp_lk[k]);
            end
        end
    endtask

    task automatic test_enable();
        int base;
        base = mv_count;
        run_lines(0, 3, 10, 32, 0);
        enable = 1'b0;
        idle(100);
        checks++;
        if (locked !== 1'b0 || h_total != 40 || h_active != 32 || v_total != 10 || v_active != 8) begin
            errors++;
            $display("FAIL enable_hold: got lk=%b %0d/%0d/%0d/%0d, expected lk=0 40/32/10/8",
                     locked, h_total, h_active, v_total, v_active);
        end
        enable = 1'b1;
        run_lines(4, 9, 10, 32, 0);
        checks++;
        if (mv_count !== base) begin
            errors++;
            $display("FAIL enable_discard: got %0d pulses, expected %0d", mv_count, base);
        end
        run_frame(10, 32, 0);
        checks++;
        if (mv_count !== base + 1 || mv_ht != 40 || mv_ha != 32 || mv_vt != 10 || mv_va != 8 || mv_lk !== 1'b0) begin
            errors++;
            $display("FAIL enable_first: got pulses=%0d %0d/%0d/%0d/%0d lk=%b, expected pulses=%0d 40/32/10/8 lk=0",
                     mv_count, mv_ht, mv_ha, mv_vt, mv_va, mv_lk, base + 1);
        end
    endtask

    task automatic test_coincident();
        run_frame(10, 36, 0);
        checks++;
        if (mv_ha != 36 || mv_ht != 40 || mv_va != 8) begin
            errors++;
            $display("FAIL de_fall_at_hsync: got ha=%0d ht=%0d va=%0d, expected ha=36 ht=40 va=8", mv_ha, mv_ht, mv_va);
        end
    endtask

    task automatic test_reset_mid();
        int base;
        run_lines(0, 0, 10, 32, 0);
        drive_line(32, 1'b0, 1'b0, 0, 19);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({h_total, h_active, v_total, v_active, interlaced, meas_valid, locked} !== '0) begin
            errors++;
            $display("FAIL reset_mid_async: got ht=%0d ha=%0d vt=%0d va=%0d il=%b mv=%b lk=%b, expected all 0",
                     h_total, h_active, v_total, v_active, interlaced, meas_valid, locked);
        end
        drive_line(32, 1'b0, 1'b0, 20, 22);
        rst_n = 1'b1;
        drive_line(32, 1'b0, 1'b0, 23, 39);
        base = mv_count;
        run_lines(2, 9, 10, 32, 0);
        checks++;
        if (mv_count !== base) begin
            errors++;
            $display("FAIL reset_mid_discard: got %0d pulses, expected %0d", mv_count, base);
        end
        run_frame(10, 32, 0);
        checks++;
        if (mv_count !== base + 1 || mv_ht != 40 || mv_ha != 32 || mv_vt != 10 || mv_va != 8 || mv_lk !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_first: got pulses=%0d %0d/%0d/%0d/%0d lk=%b, expected pulses=%0d 40/32/10/8 lk=0",
                     mv_count, mv_ht, mv_ha, mv_vt, mv_va, mv_lk, base + 1);
        end
    endtask

`ifdef VTD_INTERLACE_EN
    task automatic test_fields();
        run_frame(5, 32, 0);
        for (int k = 0; k < 3; k++) begin
            run_frame(6, 32, 1);
            run_frame(5, 32, 0);
            checks++;
            if (mv_vt != 11 || mv_il !== 1'b1) begin
                errors++;
                $display("FAIL fields_pair%0d: got vt=%0d il=%b, expected vt=11 il=1", k, mv_vt, mv_il);
            end
        end
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL fields_lock: got %b, expected 1", locked);
        end
    endtask
`else
    task automatic test_fields();
        int base;
        int n;
        base = mv_count;
        for (int k = 0; k < 4; k++) begin
            n = (k % 2 == 0) ? 5 : 6;
            run_frame(n, 32, k[0]);
            checks++;
            if (mv_vt != n || mv_va != n - 2 || mv_lk !== 1'b0 || mv_il !== 1'b0) begin
                errors++;
                $display("FAIL fields_alt%0d: got vt=%0d va=%0d lk=%b il=%b, expected vt=%0d va=%0d lk=0 il=0",
                         k, mv_vt, mv_va, mv_lk, mv_il, n, n - 2);
            end
        end
        checks++;
        if (mv_count !== base + 4 || locked !== 1'b0) begin
            errors++;
            $display("FAIL fields_count: got pulses=%0d lk=%b, expected pulses=%0d lk=0", mv_count, locked, base + 4);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_progressive();
        test_hact_change();
        test_timeout();
        test_enable();
        test_coincident();
        test_reset_mid();
        test_fields();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/video_timing_detector.md
# video_timing_detector

Measures the raster of an incoming sync/DE stream (hsync, vsync, de, field) and reports horizontal/vertical total and active sizes, plus a lock flag once the format is stable. It sits directly downstream of `video_sync_generator` on the same `pclk`. In hardware it replaces bench-side measurement, and on a capture path it qualifies an external source.

## Interface
- `H_W`, 12, width of horizontal counts and outputs.
- `V_W`, 11, width of vertical counts and outputs.
- `LOCK_FRAMES`, 2, number of consecutive identical frame measurements required for `locked` (range 1..15).

Ports:
- `pclk` input, 1, pixel clock; all logic is on its rising edge.
- `rst_n` input, 1, asynchronous active-low reset.
- `enable` input, 1, measurement enable.
- `vsync` input, 1, vertical sync, active-high.
- `hsync` input, 1, horizontal sync, active-high.
- `de` input, 1, data enable, active-high.
- `field` input, 1, field id; 0 = first field.
- `h_total` output, `H_W`, pclk cycles per line.
- `h_active` output, `H_W`, de-high cycles per line.
- `v_total` output, `V_W`, lines per frame (both fields when interlaced).
- `v_active` output, `V_W`, lines containing at least one de cycle.
- `interlaced` output, 1, source alternates field.
- `meas_valid` output, 1, one-cycle pulse when new measurements are latched.
- `locked` output, 1, format stable.

## Operation
- Inputs are registered once into `*_d` regs. Edges are computed as `x_d & ~x_q`, where `x_q` is a second register stage. No CDC logic: inputs must already be synchronous to `pclk`.
- `h_cnt`:
  - Increments every cycle.
  - On hsync rise, captures `h_cnt` into the line's h_total and reloads to 1.
  - Saturates at all-ones.
- `ha_cnt`:
  - Counts de-high cycles.
  - On de fall, captures into the line's h_active.
  - Cleared at hsync rise.
- `line_has_de` is set by any de; it is sampled and cleared at hsync rise.
- `v_cnt` increments on each hsync rise. `va_cnt` increments on hsync rise when `line_has_de` is set. Both saturate.
- Frame boundary is vsync rise, with `field`==0 (or any vsync rise when interlace support is compiled out). At the boundary:
  - Latch the last line's h_total/h_active and `v_cnt`/`va_cnt` into the outputs.
  - Pulse `meas_valid`.
  - Reload the vertical counters.
- A vsync rise with `field`==1 does not reset the vertical counters; the count accumulates across both fields.
- `primed` flag: the first frame boundary after reset or after `enable` rises only sets `primed`. No latch and no `meas_valid` occur, because the partial frame is discarded.
- Lock:
  - A 4-bit `match_cnt` compares the new {h_total, h_active, v_total, v_active} with the previous outputs.
  - On equal, `match_cnt` increments, saturating at `LOCK_FRAMES`.
  - On unequal, `match_cnt` goes to 0 and `locked` goes to 0 in the same cycle as `meas_valid`.
  - `locked` = (`match_cnt` == `LOCK_FRAMES`).
  - The first latched frame counts as `match_cnt`=0.
- Timeout: if `h_cnt` saturates, `locked` clears immediately (hsync lost).
- `enable`=0 clears all counters, `primed`, `match_cnt` and `locked`. Measurement outputs and `interlaced` hold their last values.

## Timing
- Reset values: all outputs 0; all counters, `primed` and `match_cnt` 0.
- `meas_valid` and output updates occur on the 3rd `pclk` edge after vsync is first high at a sampling edge. The pipeline is input reg, then edge reg, then output reg.
- `meas_valid` is exactly 1 cycle wide. Outputs are stable from that cycle until the next `meas_valid`.
- Simultaneous hsync rise and vsync rise: the hsync update of `v_cnt` is applied first. The frame latch includes that line, and the new frame starts with `v_cnt`=0.
- de fall coincident with hsync rise: h_active is captured before the clear.
- Reset asserted mid-frame: every register returns to its reset value asynchronously, and the next frame is discarded (unprimed).

## Configuration
- `VTD_INTERLACE_EN` defined:
  - `field` qualifies frame boundaries as above.
  - `interlaced` is set at a frame boundary if a field=1 vsync occurred since the previous boundary, else it is cleared.
- `VTD_INTERLACE_EN` undefined:
  - `field` is ignored.
  - Every vsync rise is a frame boundary.
  - `interlaced` is tied 0.

## Test plan
- Progressive 40x10 raster (h_active 32, v_active 8, `LOCK_FRAMES`=2) -> first frame discarded; `meas_valid` each frame after that with 40/32/10/8; `locked`=1 at the 3rd `meas_valid`.
- Lock established, then one frame with h_active 31 -> `locked`=0 in that `meas_valid` cycle; relocks 2 frames after 32 returns.
- Stop hsync for 4096 cycles (`H_W`=12) while locked -> `locked`=0 on the saturation cycle; `h_total`=4095 at the next `meas_valid`.
- With `VTD_INTERLACE_EN`, fields of 5 and 6 lines -> `v_total`=11, `interlaced`=1. Without the macro: `v_total` alternates 5/6 and `locked` never asserts.
- `enable` deasserted mid-frame for 100 cycles -> `locked`=0, outputs hold; after re-enable, the first boundary gives no `meas_valid`.
- `rst_n` pulsed low mid-line -> all outputs 0 immediately; `meas_valid` first appears at the 2nd vsync after release.
